key_conditioner: RTL
====================

Name: key_conditioner

Overview:
- Front-end stage directly upstream of the door-lock FSM; converts the three raw push-button inputs into clean, synchronised, debounced signals.
- Each debounced press produces a single-cycle pulse, which drives the lock's button_0..button_2 inputs.
- Also provides held levels, a multi-press flag, and gating by the lock's start signal so presses made while disarmed are never forwarded.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical synchronised samples required to accept a press or release; legal range 2..(2^CNT_W - 1).
- CNT_W, 3: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high; sampled only at the clk rising edge.
- key_raw  in  3  raw asynchronous buttons; bit i = button_i; 1 = pressed.
- enable  in  1  arm input, tied to the lock's start; 0 suppresses all pulses.
- key_pulse  out  3  one-cycle pulse per accepted press; bit i feeds button_i.
- key_level  out  3  debounced held level per key.
- multi_press  out  1  one-cycle flag; two or more key_pulse bits asserted in the same cycle.

Behaviour:
- Reset: when rst=1 at an edge, all of the following clear on that edge:
  - synchroniser flops, counters and FSMs go to RELEASED;
  - key_pulse, key_level and multi_press go to 0.
  - Reset overrides all other inputs.
- Synchroniser: two flops per key; s_i is the second-flop output. All FSM decisions use s_i only.
- Per-key FSM, four states: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK; cnt is CNT_W bits.
  - RELEASED: s=1 -> PRESS_CHK with cnt=1; else stay.
  - PRESS_CHK, s=1, cnt==DEBOUNCE_CYCLES-1 -> PRESSED; the press is accepted on this edge.
  - PRESS_CHK, s=1, otherwise -> cnt+1, stay.
  - PRESS_CHK, s=0 -> RELEASED, cnt=0 (glitch rejected).
  - PRESSED: s=0 -> RELEASE_CHK with cnt=1; else stay.
  - RELEASE_CHK, s=0, cnt==DEBOUNCE_CYCLES-1 -> RELEASED.
  - RELEASE_CHK, s=0, otherwise -> cnt+1, stay.
  - RELEASE_CHK, s=1 -> PRESSED, cnt=0 (bounce ignored; no new pulse).
  - cnt never wraps, because the exit compare happens before overflow.
- key_level[i] (registered): 1 while the FSM is in PRESSED or RELEASE_CHK.
- key_pulse[i] (registered): 1 for exactly the one cycle following the edge where PRESS_CHK->PRESSED is taken, and only if enable=1 at that edge.
  - A press accepted while enable=0 is discarded, not deferred.
  - Holding a key across an enable rise produces no pulse.
- Latency: raw held high, first captured by sync flop 1 at edge k.
  - s_i is first sampled high by the FSM at edge k+2.
  - PRESSED is entered at edge k+DEBOUNCE_CYCLES+1.
  - key_pulse and key_level rise in the cycle after that edge.
- Minimum accepted pulse width: DEBOUNCE_CYCLES cycles of stable input.
- Rate: at most one pulse per key per full press/release cycle. A continuously held key yields exactly one pulse.
- Simultaneous presses: independent keys accepted on the same edge all pulse in the same cycle, and multi_press=1 in that cycle. Presses are not serialised; the lock treats a multi-key pattern as a wrong entry.
- multi_press is registered, aligned with key_pulse, and 0 whenever fewer than two pulse bits are set.
- Reset mid-debounce or mid-press: all state is lost. A key still held after rst falls must debounce again from RELEASED and then produces one fresh pulse (if enable=1).

Decomposition:
- Shared package / header holds:
  - FSM state encodings: RELEASED=2'd0, PRESS_CHK=2'd1, PRESSED=2'd2, RELEASE_CHK=2'd3;
  - NUM_KEYS=3.
- Sub-module key_debounce: one key's two-flop synchroniser, counter and FSM, with outputs level and accept (1-cycle, unregistered-to-top).
- Top instantiates key_debounce three times and adds:
  - registered enable gating of key_pulse;
  - the population-count compare for multi_press;
  - the output registers.

Test Plan (DEBOUNCE_CYCLES=4, edge k = first capture):
- Reset: drive rst=1 for 2 cycles with key_raw=3'b111 -> all outputs 0. Release rst with keys held and enable=1 -> key_pulse=3'b111 and multi_press=1 for one cycle after edge k+5 relative to the first post-reset edge; no second pulse while held.
- Clean press: enable=1, key_raw[2] high for 10 cycles then low -> key_pulse=3'b100 for exactly one cycle after edge k+5, multi_press=0. key_level[2] is high from that cycle until 4 low samples after release.
- Glitch rejection: key_raw[0] high for 3 cycles, then low -> key_pulse and key_level stay 0; FSM returns to RELEASED.
- Release bounce: key_raw[1] pressed and accepted, then low 2 cycles / high 1 / low 6 -> exactly one pulse total; key_level[1] falls only after 4 consecutive low samples.
- Enable gating: enable=0 during press acceptance of key_raw[0], enable raised while still held -> no pulse. Release, then press again with enable=1 -> one pulse 3'b001.
- Mid-operation reset: rst=1 for one cycle while key_raw[0] is in PRESS_CHK (cnt=2) -> no pulse. With the key still held and enable=1, a pulse appears after a full debounce counted from the reset-release edge.

Source files
------------

// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the key conditioner front end.
// Holds the per-key debounce state encoding, the key count, and a small
// helper that flags multi-key patterns.
package key_conditioner_pkg;

  localparam int unsigned NUM_KEYS = 3;

  // Per-key debounce FSM states; encodings are fixed so they can be
  // probed from a waveform viewer without a lookup table.
  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_e;

  // True when two or more bits of the key vector are set.
  function automatic logic multi_hot(input logic [NUM_KEYS-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) n++;
    end
    return (n >= 2);
  endfunction

endpackage : key_conditioner_pkg

// File: rtl/key_conditioner_if.sv
// Button-side bundle between the raw key inputs / arm signal and the
// conditioned pulses consumed by the door-lock FSM.
//   key_raw     : raw asynchronous buttons, bit i = button_i, 1 = pressed
//   enable      : arm input (lock start); 0 suppresses all pulses
//   key_pulse   : one-cycle pulse per accepted press
//   key_level   : debounced held level per key
//   multi_press : one-cycle flag, two or more pulse bits in the same cycle
// master = the side that drives the buttons and consumes the outputs,
// slave  = the conditioner itself.
interface key_conditioner_if;
  import key_conditioner_pkg::*;

  logic [NUM_KEYS-1:0] key_raw;
  logic                enable;
  logic [NUM_KEYS-1:0] key_pulse;
  logic [NUM_KEYS-1:0] key_level;
  logic                multi_press;

  modport master (
    output key_raw,
    output enable,
    input  key_pulse,
    input  key_level,
    input  multi_press
  );

  modport slave (
    input  key_raw,
    input  enable,
    output key_pulse,
    output key_level,
    output multi_press
  );

endinterface : key_conditioner_if

// File: rtl/key_debounce.sv
// Single-key conditioner: two-flop synchroniser followed by a four-state
// debounce FSM with a saturating-by-construction counter.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   key_raw_i  : raw asynchronous button input
//   level_o    : next-cycle debounced level (high in PRESSED / RELEASE_CHK);
//                the top registers it so it lines up with the state register
//   accept_o   : high during the cycle whose closing edge takes
//                PRESS_CHK -> PRESSED (combinational)
module key_debounce
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw_i,
  output logic level_o,
  output logic accept_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  key_state_e       state_q;
  key_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Two-flop synchroniser; only sync2_q is used by the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The exit compare against CNT_LAST happens before the
  // counter could overflow, so cnt never wraps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_o = 1'b0;

    unique case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          state_d = PRESS_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      PRESS_CHK: begin
        if (!sync2_q) begin
          // Glitch shorter than the debounce window: drop it.
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = PRESSED;
          cnt_d    = '0;
          accept_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASE_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      RELEASE_CHK: begin
        if (sync2_q) begin
          // Release bounce: back to held without issuing a new press.
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Level follows the state about to be entered, so a register on it in the
  // top tracks state_q exactly.
  always_comb begin
    level_o = (state_d == PRESSED) || (state_d == RELEASE_CHK);
  end

endmodule : key_debounce

// File: rtl/key_conditioner.sv
// Push-button front end for the door lock: synchronises and debounces each
// raw key, emits one registered pulse per accepted press (only while armed),
// a registered held level per key, and a flag for multi-key patterns.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset, overrides everything
//   bus  : key_conditioner_if.slave
//          key_raw/enable in; key_pulse/key_level/multi_press out
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic               clk,
  input  logic               rst,
  key_conditioner_if.slave   bus
);

  logic [NUM_KEYS-1:0] accept;
  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] key_pulse_d;
  logic [NUM_KEYS-1:0] key_pulse_q;
  logic [NUM_KEYS-1:0] key_level_q;
  logic                multi_press_d;
  logic                multi_press_q;

  // One independent debouncer per key.
  for (genvar i = 0; i < int'(NUM_KEYS); i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .key_raw_i (bus.key_raw[i]),
      .level_o   (level[i]),
      .accept_o  (accept[i])
    );
  end

  // Presses accepted while disarmed are dropped, not deferred.
  always_comb begin
    key_pulse_d   = bus.enable ? accept : '0;
    multi_press_d = multi_hot(key_pulse_d);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_pulse_q   <= '0;
      key_level_q   <= '0;
      multi_press_q <= 1'b0;
    end else begin
      key_pulse_q   <= key_pulse_d;
      key_level_q   <= level;
      multi_press_q <= multi_press_d;
    end
  end

  assign bus.key_pulse   = key_pulse_q;
  assign bus.key_level   = key_level_q;
  assign bus.multi_press = multi_press_q;

endmodule : key_conditioner
